// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: imem req/ack port, redirect/trap inputs and decode-side output of the fetch sequencer
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr,
        input  imem_ack, imem_rdata, redirect_valid, redirect_target, trap_valid, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr,
        output imem_ack, imem_rdata, redirect_valid, redirect_target, trap_valid, out_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and fetch sequencer; one outstanding imem request, output reg plus skid,
// branch/trap redirect with flush and drain of an abandoned request
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0010,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, STALL, DRAIN} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, drain_q, drain_d;
    logic        req_q;
    logic        ov_q, ov_d, sv_q, sv_d;
    logic [31:0] opc_q, opc_d, oins_q, oins_d, spc_q, spc_d, sins_q, sins_d;
    logic        redir, take, can_load, ack;
    assign ack      = bus.imem_ack;
    assign redir    = bus.trap_valid | bus.redirect_valid;
    assign take     = ov_q & bus.out_ready;
    assign can_load = !ov_q | bus.out_ready;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drain_d = drain_q;
        ov_d    = take ? 1'b0 : ov_q;
        opc_d   = opc_q;
        oins_d  = take ? NOP_INSTR : oins_q;
        sv_d    = sv_q;
        spc_d   = spc_q;
        sins_d  = sins_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: if (ack) begin
                pc_d = pc_q + 32'd4;
                if (can_load) begin
                    ov_d   = 1'b1;
                    opc_d  = pc_q;
                    oins_d = bus.imem_rdata;
                end else begin
                    sv_d    = 1'b1;
                    spc_d   = pc_q;
                    sins_d  = bus.imem_rdata;
                    state_d = STALL;
                end
            end
            STALL: if (take) begin
                ov_d    = 1'b1;
                opc_d   = spc_q;
                oins_d  = sins_q;
                sv_d    = 1'b0;
                state_d = REQ;
            end
            DRAIN: state_d = ack ? REQ : DRAIN;
            default: state_d = IDLE;
        endcase
        // Redirect flushes everything; an unacked request keeps its old address in drain_q
        if (redir) begin
            pc_d   = bus.trap_valid ? TRAP_VEC : {bus.redirect_target[31:2], 2'b00};
            ov_d   = 1'b0;
            oins_d = NOP_INSTR;
            sv_d   = 1'b0;
            if (state_q == REQ && !ack) begin
                state_d = DRAIN;
                drain_d = pc_q;
            end else if (state_q != DRAIN) begin
                state_d = REQ;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            drain_q <= '0;
            req_q   <= 1'b0;
            ov_q    <= 1'b0;
            opc_q   <= '0;
            oins_q  <= NOP_INSTR;
            sv_q    <= 1'b0;
            spc_q   <= '0;
            sins_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
            req_q   <= (state_d == REQ) || (state_d == DRAIN);
            ov_q    <= ov_d;
            opc_q   <= opc_d;
            oins_q  <= oins_d;
            sv_q    <= sv_d;
            spc_q   <= spc_d;
            sins_q  <= sins_d;
        end
    end
    assign bus.imem_req  = req_q;
    assign bus.imem_addr = (state_q == DRAIN) ? drain_q : pc_q;
    assign bus.out_valid = ov_q;
    assign bus.out_pc    = opc_q;
    assign bus.out_instr = oins_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random wait-state memory and consumer; checks the delivered instruction stream
// against an expected-PC model plus req/out hold rules and directed corner cases
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    fetch_ctrl_if bus();
    fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int wmin = 0, wmax = 0, rdy_pct = 100, redir_pct = 0, trap_pct = 0;
    bit force_redir = 0, force_trap = 0;
    logic [31:0] force_tgt = '0;
    int wait_left = 0, since_rst = 0, transfers = 0, acks = 0;
    bit in_flight = 0, new_start = 0, saw_wrap = 0, has_last = 0;
    logic [31:0] exp_pc = RESET_PC, start_addr = '0, last_xfer = '0;
    bit p_req = 0, p_ack = 0, p_ov = 0, p_rdy = 0, p_redir = 0;
    logic [31:0] p_addr = '0, p_pc = '0, p_ins = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs from current outputs, advance the stream model, clock, check holds.
    task automatic step();
        bit r, rd, tr;
        logic [31:0] tgt;
        r = reset;
        if (r) in_flight = 0;
        new_start = bus.imem_req && !in_flight && !r;
        if (new_start) begin
            in_flight = 1;
            wait_left = int'($urandom_range(wmax, wmin));
            start_addr = bus.imem_addr;
        end
        rd  = !r && (force_redir || ($urandom_range(99, 0) < redir_pct));
        tr  = !r && (force_redir ? force_trap : ($urandom_range(99, 0) < trap_pct));
        tgt = force_redir ? force_tgt : $urandom;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        if (in_flight && !r && !force_redir) begin
            if (wait_left == 0) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = mem(bus.imem_addr);
                in_flight = 0;
                acks++;
            end else wait_left--;
        end
        bus.out_ready = $urandom_range(99, 0) < rdy_pct;
        bus.redirect_valid = rd;
        bus.trap_valid = tr;
        bus.redirect_target = tgt;
        force_redir = 0;
        if (r) exp_pc = RESET_PC;
        else begin
            if (bus.out_valid && bus.out_ready) begin
                transfers++;
                check("out_pc", bus.out_pc, exp_pc);
                check("out_instr", bus.out_instr, mem(exp_pc));
                if (has_last && last_xfer == 32'hFFFF_FFFC && bus.out_pc == 32'h0) saw_wrap = 1;
                last_xfer = bus.out_pc;
                has_last = 1;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd || tr) exp_pc = tr ? TRAP_VEC : {tgt[31:2], 2'b00};
        end
        p_req = bus.imem_req; p_ack = bus.imem_ack; p_addr = bus.imem_addr;
        p_ov = bus.out_valid; p_rdy = bus.out_ready; p_redir = rd || tr;
        p_pc = bus.out_pc; p_ins = bus.out_instr;
        @(posedge clk);
        #1;
        if (r) begin
            since_rst = 0;
            has_last = 0;
            check("rst_req", 32'(bus.imem_req), 32'h0);
            check("rst_valid", 32'(bus.out_valid), 32'h0);
            check("rst_out_pc", bus.out_pc, 32'h0);
        end else begin
            since_rst++;
            if (p_req && !p_ack) begin
                check("req_held", 32'(bus.imem_req), 32'h1);
                check("addr_held", bus.imem_addr, p_addr);
            end
            if (p_ov && !p_rdy && !p_redir) begin
                check("out_held_valid", 32'(bus.out_valid), 32'h1);
                check("out_held_pc", bus.out_pc, p_pc);
                check("out_held_instr", bus.out_instr, p_ins);
            end
            if (since_rst == 1) begin
                check("first_req", 32'(bus.imem_req), 32'h1);
                check("first_addr", bus.imem_addr, exp_pc);
            end
        end
        if (bus.imem_req) check("addr_align", 32'(bus.imem_addr[1:0]), 32'h0);
        if (!bus.out_valid) check("idle_instr", bus.out_instr, NOP);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic await_new_start(input string tag, input logic [31:0] exp_addr);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (new_start) begin
                found = 1;
                break;
            end
        end
        check({tag, "_start_seen"}, 32'(found), 32'h1);
        check({tag, "_start_addr"}, start_addr, exp_addr);
    endtask

    // Redirect while the request at 8 is outstanding and unacked; drained ack must not leak.
    task automatic redirect_at_8(input string tag, input bit trap, input logic [31:0] tgt,
                                 input logic [31:0] exp_addr);
        bit found = 0;
        do_reset();
        wmin = 2; wmax = 2; rdy_pct = 100;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.imem_req && bus.imem_addr == 32'h8) begin
                found = 1;
                break;
            end
        end
        check({tag, "_reach8"}, 32'(found), 32'h1);
        force_redir = 1; force_trap = trap; force_tgt = tgt;
        step();
        check({tag, "_flush"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_drain_req"}, 32'(bus.imem_req), 32'h1);
        check({tag, "_drain_addr"}, bus.imem_addr, 32'h8);
        await_new_start(tag, exp_addr);
        repeat (8) step();
    endtask

    initial begin
        int t0;
        bit found;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.redirect_valid = 1'b0;
        bus.redirect_target = '0; bus.trap_valid = 1'b0; bus.out_ready = 1'b0;
        // zero-wait memory, always-ready decode: one word per cycle
        reset = 1'b1;
        step();
        do_reset();
        step();
        step();
        check("t1_first_valid", 32'(bus.out_valid), 32'h1);
        check("t1_pc0", bus.out_pc, 32'h0);
        step();
        check("t1_pc4", bus.out_pc, 32'h4);
        step();
        check("t1_pc8", bus.out_pc, 32'h8);
        step();
        check("t1_pcC", bus.out_pc, 32'hC);
        // three wait states per request
        do_reset();
        wmin = 3; wmax = 3;
        acks = 0;
        repeat (20) step();
        check("t2_acks", 32'(acks), 32'd4);
        // decode stalls: output holds, skid fills, fetch stops
        do_reset();
        wmin = 0; wmax = 0; rdy_pct = 0;
        repeat (7) step();
        check("t3_stall_req", 32'(bus.imem_req), 32'h0);
        check("t3_hold_valid", 32'(bus.out_valid), 32'h1);
        check("t3_hold_pc", bus.out_pc, 32'h0);
        rdy_pct = 100;
        t0 = transfers;
        repeat (6) step();
        check("t3_xfers", 32'(transfers - t0), 32'd6);
        redirect_at_8("t4", 1'b0, 32'h0000_0103, 32'h0000_0100);
        redirect_at_8("t5", 1'b1, 32'h0000_0204, TRAP_VEC);
        // wrap-around then reset while draining
        redirect_at_8("t6", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        saw_wrap = 0;
        wmin = 0; wmax = 0;
        force_redir = 1; force_trap = 0; force_tgt = 32'hFFFF_FFF8;
        step();
        await_new_start("t6_seq", 32'hFFFF_FFF8);
        await_new_start("t6_next", 32'hFFFF_FFFC);
        await_new_start("t6_wrap", 32'h0);
        repeat (6) step();
        check("t6_saw_wrap", 32'(saw_wrap), 32'h1);
        wmin = 3; wmax = 3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.imem_req && new_start) begin
                found = 1;
                break;
            end
        end
        check("t6_req_seen", 32'(found), 32'h1);
        force_redir = 1; force_trap = 0; force_tgt = 32'h0000_0200;
        step();
        check("t6_drain_req", 32'(bus.imem_req), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("t6_reset_pc", bus.imem_addr, RESET_PC);
        // random traffic
        do_reset();
        wmin = 0; wmax = 3; rdy_pct = 75; redir_pct = 5; trap_pct = 2;
        t0 = transfers;
        repeat (3000) step();
        check("rand_progress", 32'(transfers - t0 > 300), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
